// File: rtl/multicycle_control_if.sv
// Control bundle between the multi-cycle sequencer and the MIPS datapath.
// The sequencer drives through "master". The datapath, or a bench, connects through "slave".
interface multicycle_control_if;
    logic [5:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       pc_write;
    logic       ir_write;
    logic       mem_read;
    logic       mem_write;
    logic       iord;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       instr_done;
    logic       illegal;
    logic       bus_error;
    logic [3:0] state;

    modport master (
        input  opcode, zero, mem_ready,
        output pc_write, ir_write, mem_read, mem_write, iord, reg_write, reg_dst,
               mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_source, instr_done,
               illegal, bus_error, state
    );

    modport slave (
        output opcode, zero, mem_ready,
        input  pc_write, ir_write, mem_read, mem_write, iord, reg_write, reg_dst,
               mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_source, instr_done,
               illegal, bus_error, state
    );
endinterface

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle MIPS control sequencer: FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK over one memory and one ALU.
// Handshake: a memory access completes in any cycle where mem_ready=1 while mem_read or mem_write is asserted.
module multicycle_control_fsm #(
    parameter int unsigned WAIT_LIMIT = 16,
    parameter int unsigned WAIT_W     = 5
) (
    input logic                  clk,
    input logic                  nrst,
    multicycle_control_if.master cif
);
    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,  S_DECODE = 4'd1,  S_MEM_ADDR = 4'd2,  S_MEM_RD = 4'd3,
        S_MEM_WB   = 4'd4,  S_MEM_WR = 4'd5,  S_EXEC_R   = 4'd6,  S_R_WB   = 4'd7,
        S_EXEC_I   = 4'd8,  S_I_WB   = 4'd9,  S_BRANCH   = 4'd10, S_JUMP   = 4'd11,
        S_TRAP     = 4'd12
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [WAIT_W-1:0] WAIT_LAST = (WAIT_LIMIT == 0) ? '0 : WAIT_W'(WAIT_LIMIT - 1);

    // Registered state decode. The *_rdy and *_taken fields mark the few input-gated terms.
    typedef struct packed {
        logic       pc_write;
        logic       pc_write_rdy;
        logic       pc_write_taken;
        logic       ir_write_rdy;
        logic       mem_read;
        logic       mem_write;
        logic       iord;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       done;
        logic       done_rdy;
    } ctrl_t;

    function automatic ctrl_t decode(input state_e s);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.mem_read = 1'b1; c.alu_src_b = 2'b01;
                c.pc_write_rdy = 1'b1; c.ir_write_rdy = 1'b1;
            end
            S_DECODE:             c.alu_src_b = 2'b11;
            S_MEM_ADDR, S_EXEC_I: begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
            S_MEM_RD:             begin c.mem_read = 1'b1; c.iord = 1'b1; end
            S_MEM_WB:             begin c.reg_write = 1'b1; c.mem_to_reg = 1'b1; c.done = 1'b1; end
            S_MEM_WR:             begin c.mem_write = 1'b1; c.iord = 1'b1; c.done_rdy = 1'b1; end
            S_EXEC_R:             begin c.alu_src_a = 1'b1; c.alu_op = 2'b10; end
            S_R_WB:               begin c.reg_write = 1'b1; c.reg_dst = 1'b1; c.done = 1'b1; end
            S_I_WB:               begin c.reg_write = 1'b1; c.done = 1'b1; end
            S_BRANCH: begin
                c.alu_src_a = 1'b1; c.alu_op = 2'b01; c.pc_source = 2'b01;
                c.pc_write_taken = 1'b1; c.done = 1'b1;
            end
            S_JUMP:               begin c.pc_source = 2'b10; c.pc_write = 1'b1; c.done = 1'b1; end
            default:              c = '0;
        endcase
        return c;
    endfunction

    state_e            state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              illegal_q, bus_error_q;
    logic              set_illegal, set_bus_error;
    logic              timeout;
    ctrl_t             ctrl_q;

    assign timeout = (WAIT_LIMIT != 0) && (wait_q == WAIT_LAST);

    // The wait counter only advances while a state holds, so it reads zero on every entry.
    always_comb begin
        state_d       = state_q;
        wait_d        = '0;
        set_illegal   = 1'b0;
        set_bus_error = 1'b0;
        case (state_q)
            S_FETCH, S_MEM_RD, S_MEM_WR: begin
                if (cif.mem_ready) begin
                    if (state_q == S_FETCH)       state_d = S_DECODE;
                    else if (state_q == S_MEM_RD) state_d = S_MEM_WB;
                    else                          state_d = S_FETCH;
                end else if (timeout) begin
                    state_d       = S_TRAP;
                    set_bus_error = 1'b1;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            S_DECODE: begin
                case (cif.opcode)
                    OP_RTYPE:       state_d = S_EXEC_R;
                    OP_ADDI:        state_d = S_EXEC_I;
                    OP_LW, OP_SW:   state_d = S_MEM_ADDR;
                    OP_BEQ, OP_BNE: state_d = S_BRANCH;
                    OP_J:           state_d = S_JUMP;
                    default: begin state_d = S_TRAP; set_illegal = 1'b1; end
                endcase
            end
            S_MEM_ADDR: begin
                if (cif.opcode == OP_LW)      state_d = S_MEM_RD;
                else if (cif.opcode == OP_SW) state_d = S_MEM_WR;
                else begin state_d = S_TRAP; set_illegal = 1'b1; end
            end
            S_EXEC_R:                               state_d = S_R_WB;
            S_EXEC_I:                               state_d = S_I_WB;
            S_R_WB, S_I_WB, S_MEM_WB, S_BRANCH, S_JUMP: state_d = S_FETCH;
            S_TRAP:                                 state_d = S_TRAP;
            default: begin state_d = S_TRAP; set_illegal = 1'b1; end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q     <= S_FETCH;
            wait_q      <= '0;
            illegal_q   <= 1'b0;
            bus_error_q <= 1'b0;
            ctrl_q      <= decode(S_FETCH);
        end else begin
            state_q     <= state_d;
            wait_q      <= wait_d;
            illegal_q   <= illegal_q | set_illegal;
            bus_error_q <= bus_error_q | set_bus_error;
            ctrl_q      <= decode(state_d);
        end
    end

    // nrst gates every control so a reset cycle can never complete a write.
    assign cif.pc_write   = nrst & (ctrl_q.pc_write
                                  | (ctrl_q.pc_write_rdy & cif.mem_ready)
                                  | (ctrl_q.pc_write_taken & (cif.zero ^ cif.opcode[0])));
    assign cif.ir_write   = nrst & ctrl_q.ir_write_rdy & cif.mem_ready;
    assign cif.mem_read   = nrst & ctrl_q.mem_read;
    assign cif.mem_write  = nrst & ctrl_q.mem_write;
    assign cif.iord       = nrst & ctrl_q.iord;
    assign cif.reg_write  = nrst & ctrl_q.reg_write;
    assign cif.reg_dst    = nrst & ctrl_q.reg_dst;
    assign cif.mem_to_reg = nrst & ctrl_q.mem_to_reg;
    assign cif.alu_src_a  = nrst & ctrl_q.alu_src_a;
    assign cif.alu_src_b  = {2{nrst}} & ctrl_q.alu_src_b;
    assign cif.alu_op     = {2{nrst}} & ctrl_q.alu_op;
    assign cif.pc_source  = {2{nrst}} & ctrl_q.pc_source;
    assign cif.instr_done = nrst & (ctrl_q.done | (ctrl_q.done_rdy & cif.mem_ready));
    assign cif.illegal    = illegal_q;
    assign cif.bus_error  = bus_error_q;
    assign cif.state      = state_q;
endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed table-driven bench for multicycle_control_fsm plus hand-written multi-cycle sequences.
// Controls are packed as {pcw,irw,mrd,mwr,iord,rw,rdst,m2r,srca,srcb,aluop,pcsrc,done,ill,berr}.
module tb_multicycle_control_fsm;
    logic clk = 1'b0;
    logic nrst;
    always #5 clk = ~clk;

    multicycle_control_if bif();

    multicycle_control_fsm #(.WAIT_LIMIT(16), .WAIT_W(5)) dut (
        .clk  (clk),
        .nrst (nrst),
        .cif  (bif.master)
    );

    typedef struct packed {
        logic        nrst;
        logic [5:0]  op;
        logic        zero;
        logic        rdy;
        logic [3:0]  st;
        logic [17:0] ctrl;
    } vec_t;

    localparam logic [17:0] C_RST      = 18'b0_0_0_0_0_0_0_0_0_00_00_00_0_0_0;
    localparam logic [17:0] C_FETCH_W  = 18'b0_0_1_0_0_0_0_0_0_01_00_00_0_0_0;
    localparam logic [17:0] C_FETCH_R  = 18'b1_1_1_0_0_0_0_0_0_01_00_00_0_0_0;
    localparam logic [17:0] C_DECODE   = 18'b0_0_0_0_0_0_0_0_0_11_00_00_0_0_0;
    localparam logic [17:0] C_EXEC_R   = 18'b0_0_0_0_0_0_0_0_1_00_10_00_0_0_0;
    localparam logic [17:0] C_R_WB     = 18'b0_0_0_0_0_1_1_0_0_00_00_00_1_0_0;
    localparam logic [17:0] C_IMM      = 18'b0_0_0_0_0_0_0_0_1_10_00_00_0_0_0;
    localparam logic [17:0] C_I_WB     = 18'b0_0_0_0_0_1_0_0_0_00_00_00_1_0_0;
    localparam logic [17:0] C_MEM_RD   = 18'b0_0_1_0_1_0_0_0_0_00_00_00_0_0_0;
    localparam logic [17:0] C_MEM_WB   = 18'b0_0_0_0_0_1_0_1_0_00_00_00_1_0_0;
    localparam logic [17:0] C_MEM_WR_W = 18'b0_0_0_1_1_0_0_0_0_00_00_00_0_0_0;
    localparam logic [17:0] C_MEM_WR_R = 18'b0_0_0_1_1_0_0_0_0_00_00_00_1_0_0;
    localparam logic [17:0] C_BR_T     = 18'b1_0_0_0_0_0_0_0_1_00_01_01_1_0_0;
    localparam logic [17:0] C_BR_N     = 18'b0_0_0_0_0_0_0_0_1_00_01_01_1_0_0;
    localparam logic [17:0] C_JUMP     = 18'b1_0_0_0_0_0_0_0_0_00_00_10_1_0_0;
    localparam logic [17:0] C_TRAP_ILL = 18'b0_0_0_0_0_0_0_0_0_00_00_00_0_1_0;
    localparam logic [17:0] C_TRAP_BUS = 18'b0_0_0_0_0_0_0_0_0_00_00_00_0_0_1;

    localparam logic [5:0] OP_R = 6'b000000, OP_ADDI = 6'b001000, OP_LW = 6'b100011;
    localparam logic [5:0] OP_SW = 6'b101011, OP_BEQ = 6'b000100, OP_BNE = 6'b000101;
    localparam logic [5:0] OP_J = 6'b000010, OP_BAD = 6'b111111;

    int checks_total  = 0;
    int checks_passed = 0;

    logic [17:0] act_ctrl;
    assign act_ctrl = {bif.pc_write, bif.ir_write, bif.mem_read, bif.mem_write, bif.iord,
                       bif.reg_write, bif.reg_dst, bif.mem_to_reg, bif.alu_src_a,
                       bif.alu_src_b, bif.alu_op, bif.pc_source, bif.instr_done,
                       bif.illegal, bif.bus_error};

    function automatic vec_t mk(input logic n, input logic [5:0] op, input logic z,
                                input logic r, input logic [3:0] st, input logic [17:0] c);
        vec_t v;
        v.nrst = n; v.op = op; v.zero = z; v.rdy = r; v.st = st; v.ctrl = c;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks_total++;
        if (act === exp) checks_passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // One cycle: drive at the falling edge, sample 1ns later, well clear of the rising edge.
    task automatic apply(input vec_t v, input string name);
        @(negedge clk);
        nrst          = v.nrst;
        bif.opcode    = v.op;
        bif.zero      = v.zero;
        bif.mem_ready = v.rdy;
        #1;
        check({name, ".state"}, 32'(bif.state), 32'(v.st));
        check({name, ".ctrl"}, 32'(act_ctrl), 32'(v.ctrl));
    endtask

    vec_t tbl[$];

    initial begin
        // Reset check, then R, ADDI, LW (3 waits), SW (2 waits), branches, jump after fetch waits.
        tbl.push_back(mk(0, OP_R,    0, 1, 4'd0,  C_RST));
        tbl.push_back(mk(1, OP_R,    0, 1, 4'd0,  C_FETCH_R));
        tbl.push_back(mk(1, OP_R,    0, 1, 4'd1,  C_DECODE));
        tbl.push_back(mk(1, OP_R,    0, 1, 4'd6,  C_EXEC_R));
        tbl.push_back(mk(1, OP_R,    0, 1, 4'd7,  C_R_WB));
        tbl.push_back(mk(1, OP_ADDI, 0, 1, 4'd0,  C_FETCH_R));
        tbl.push_back(mk(1, OP_ADDI, 0, 1, 4'd1,  C_DECODE));
        tbl.push_back(mk(1, OP_ADDI, 0, 1, 4'd8,  C_IMM));
        tbl.push_back(mk(1, OP_ADDI, 0, 1, 4'd9,  C_I_WB));
        tbl.push_back(mk(1, OP_LW,   0, 1, 4'd0,  C_FETCH_R));
        tbl.push_back(mk(1, OP_LW,   0, 1, 4'd1,  C_DECODE));
        tbl.push_back(mk(1, OP_LW,   0, 0, 4'd2,  C_IMM));
        tbl.push_back(mk(1, OP_LW,   0, 0, 4'd3,  C_MEM_RD));
        tbl.push_back(mk(1, OP_LW,   0, 0, 4'd3,  C_MEM_RD));
        tbl.push_back(mk(1, OP_LW,   0, 0, 4'd3,  C_MEM_RD));
        tbl.push_back(mk(1, OP_LW,   0, 1, 4'd3,  C_MEM_RD));
        tbl.push_back(mk(1, OP_LW,   0, 1, 4'd4,  C_MEM_WB));
        tbl.push_back(mk(1, OP_SW,   0, 1, 4'd0,  C_FETCH_R));
        tbl.push_back(mk(1, OP_SW,   0, 1, 4'd1,  C_DECODE));
        tbl.push_back(mk(1, OP_SW,   0, 1, 4'd2,  C_IMM));
        tbl.push_back(mk(1, OP_SW,   0, 0, 4'd5,  C_MEM_WR_W));
        tbl.push_back(mk(1, OP_SW,   0, 0, 4'd5,  C_MEM_WR_W));
        tbl.push_back(mk(1, OP_SW,   0, 1, 4'd5,  C_MEM_WR_R));
        tbl.push_back(mk(1, OP_BEQ,  1, 1, 4'd0,  C_FETCH_R));
        tbl.push_back(mk(1, OP_BEQ,  1, 1, 4'd1,  C_DECODE));
        tbl.push_back(mk(1, OP_BEQ,  1, 1, 4'd10, C_BR_T));
        tbl.push_back(mk(1, OP_BEQ,  0, 1, 4'd0,  C_FETCH_R));
        tbl.push_back(mk(1, OP_BEQ,  0, 1, 4'd1,  C_DECODE));
        tbl.push_back(mk(1, OP_BEQ,  0, 1, 4'd10, C_BR_N));
        tbl.push_back(mk(1, OP_BNE,  0, 1, 4'd0,  C_FETCH_R));
        tbl.push_back(mk(1, OP_BNE,  0, 1, 4'd1,  C_DECODE));
        tbl.push_back(mk(1, OP_BNE,  0, 1, 4'd10, C_BR_T));
        tbl.push_back(mk(1, OP_BNE,  1, 1, 4'd0,  C_FETCH_R));
        tbl.push_back(mk(1, OP_BNE,  1, 1, 4'd1,  C_DECODE));
        tbl.push_back(mk(1, OP_BNE,  1, 1, 4'd10, C_BR_N));
        tbl.push_back(mk(1, OP_J,    0, 0, 4'd0,  C_FETCH_W));
        tbl.push_back(mk(1, OP_J,    0, 0, 4'd0,  C_FETCH_W));
        tbl.push_back(mk(1, OP_J,    0, 1, 4'd0,  C_FETCH_R));
        tbl.push_back(mk(1, OP_J,    0, 1, 4'd1,  C_DECODE));
        tbl.push_back(mk(1, OP_J,    0, 1, 4'd11, C_JUMP));

        nrst          = 1'b0;
        bif.opcode    = '0;
        bif.zero      = 1'b0;
        bif.mem_ready = 1'b0;
        repeat (2) @(posedge clk);

        for (int i = 0; i < tbl.size(); i++)
            apply(tbl[i], $sformatf("tbl[%0d]", i));

        // Illegal opcode: trap holds for 20 cycles whatever the inputs, cleared only by reset.
        apply(mk(1, OP_BAD, 0, 1, 4'd0, C_FETCH_R), "ill_fetch");
        apply(mk(1, OP_BAD, 0, 1, 4'd1, C_DECODE),  "ill_decode");
        for (int i = 0; i < 20; i++) begin
            logic [1:0] iv;
            iv = 2'(i);
            apply(mk(1, OP_BAD, iv[0], iv[1], 4'd12, C_TRAP_ILL), $sformatf("ill_trap[%0d]", i));
        end
        apply(mk(0, OP_BAD, 0, 1, 4'd12, C_TRAP_ILL), "ill_rst");
        apply(mk(1, OP_R,   0, 0, 4'd0,  C_FETCH_W),  "ill_after_rst");

        // Fetch timeout: 16 waiting cycles then TRAP with bus_error.
        apply(mk(0, OP_R, 0, 0, 4'd0, C_RST), "to_rst");
        for (int i = 0; i < 16; i++)
            apply(mk(1, OP_R, 0, 0, 4'd0, C_FETCH_W), $sformatf("to_wait[%0d]", i));
        apply(mk(1, OP_R, 0, 0, 4'd12, C_TRAP_BUS), "to_trap");
        apply(mk(0, OP_R, 0, 0, 4'd12, C_TRAP_BUS), "to_trap_rst");

        // Ready on the 16th wait cycle wins over the timeout.
        for (int i = 0; i < 15; i++)
            apply(mk(1, OP_R, 0, 0, 4'd0, C_FETCH_W), $sformatf("edge_wait[%0d]", i));
        apply(mk(1, OP_R, 0, 1, 4'd0, C_FETCH_R), "edge_ready");
        apply(mk(1, OP_R, 0, 1, 4'd1, C_DECODE),  "edge_decode");
        apply(mk(1, OP_R, 0, 1, 4'd6, C_EXEC_R),  "edge_exec");
        apply(mk(1, OP_R, 0, 1, 4'd7, C_R_WB),    "edge_wb");

        // Reset in the middle of a store wait: no write, no instr_done, back to FETCH.
        apply(mk(1, OP_SW, 0, 1, 4'd0, C_FETCH_R),  "swr_fetch");
        apply(mk(1, OP_SW, 0, 1, 4'd1, C_DECODE),   "swr_decode");
        apply(mk(1, OP_SW, 0, 0, 4'd2, C_IMM),      "swr_addr");
        apply(mk(1, OP_SW, 0, 0, 4'd5, C_MEM_WR_W), "swr_wait");
        apply(mk(0, OP_SW, 0, 1, 4'd5, C_RST),      "swr_rst");
        apply(mk(1, OP_SW, 0, 0, 4'd0, C_FETCH_W),  "swr_after");

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end
endmodule
